register_file_2r1w: RTL and testbench

- Parametrised successor of the single-port register file.
- Two independent registered read ports, one write port with write enable, and write-to-read bypass.
- Sequential bulk-clear engine wipes the whole array one entry per cycle.
- Sits as the general-purpose register storage beside the datapath.

---
 rtl/register_file_2r1w.sv | 136 +++++++++++++
 tb/tb_register_file_2r1w.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/register_file_2r1w.sv
// Two-read, one-write register file with write bypass and a sequential bulk-clear engine.
// Latency: reads are registered, 1 cycle; a clear takes DEPTH cycles.
// Backpressure: none; writes arriving while busy is high are silently dropped.
// Optional: define REG_ZERO_HARDWIRED_EN to hardwire entry 0 to zero.
module register_file_2r1w #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr_a,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0]    rd_data_a,
  output logic [DATA_WIDTH-1:0]    rd_data_b,
  input  logic                     clr_req,
  output logic                     busy
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = {ADDRESS_WIDTH{1'b1}};

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [ADDRESS_WIDTH-1:0]  clr_cnt;
  logic [ADDRESS_WIDTH-1:0]  clr_cnt_nxt;
  logic [DATA_WIDTH-1:0]     mem [DEPTH];
  logic                      wr_accept;
  logic [DATA_WIDTH-1:0]     rd_nxt_a;
  logic [DATA_WIDTH-1:0]     rd_nxt_b;

  // Writes only land while idle; with entry 0 hardwired, writes to it vanish
  // here so neither the array nor the bypass path ever sees them.
`ifdef REG_ZERO_HARDWIRED_EN
  assign wr_accept = wr_en && (state == IDLE) && (wr_addr != '0);
`else
  assign wr_accept = wr_en && (state == IDLE);
`endif

  // Clear engine next state: start from IDLE on clr_req, walk the counter,
  // leave on the last entry. clr_req during CLEAR is simply not looked at.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      CLEAR: begin
        if (clr_cnt == LAST_ADDR) begin
          state_nxt   = IDLE;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  // FSM state, clear counter and registered busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      clr_cnt <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      busy    <= (state_nxt == CLEAR);
    end
  end

  // Storage array: the clear engine owns the write port while running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_accept) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read data for the coming edge: the entry being cleared reads as zero,
  // a same-edge write forwards its new data, otherwise the stored value.
  always_comb begin
    rd_nxt_a = mem[rd_addr_a];
    rd_nxt_b = mem[rd_addr_b];
    if ((state == CLEAR) && (rd_addr_a == clr_cnt)) begin
      rd_nxt_a = '0;
    end else if (wr_accept && (rd_addr_a == wr_addr)) begin
      rd_nxt_a = wr_data;
    end
    if ((state == CLEAR) && (rd_addr_b == clr_cnt)) begin
      rd_nxt_b = '0;
    end else if (wr_accept && (rd_addr_b == wr_addr)) begin
      rd_nxt_b = wr_data;
    end
`ifdef REG_ZERO_HARDWIRED_EN
    if (rd_addr_a == '0) begin
      rd_nxt_a = '0;
    end
    if (rd_addr_b == '0) begin
      rd_nxt_b = '0;
    end
`endif
  end

  // Registered read ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      rd_data_a <= rd_nxt_a;
      rd_data_b <= rd_nxt_b;
    end
  end

endmodule

// File: tb/tb_register_file_2r1w.sv
module tb_register_file_2r1w;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
`ifdef REG_ZERO_HARDWIRED_EN
  localparam bit ZHW = 1'b1;
`else
  localparam bit ZHW = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [DW-1:0] rd_data_a;
  logic [DW-1:0] rd_data_b;
  logic          clr_req;
  logic          busy;

  register_file_2r1w #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .clr_req   (clr_req),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic          clr;
    logic          ca;
    logic [DW-1:0] ea;
    logic          cb;
    logic [DW-1:0] eb;
    logic          ebusy;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  int            busy_hi = 0;
  vec_t          exp_q[$];
  vec_t          tbl[9];
  logic [DW-1:0] model_mem [DEPTH];

  task automatic check(input string nm, input int idx, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic clr,
                              input logic ca, input logic [DW-1:0] ea,
                              input logic cb, input logic [DW-1:0] eb, input logic ebusy);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb; v.clr = clr;
    v.ca = ca; v.ea = ea; v.cb = cb; v.eb = eb; v.ebusy = ebusy;
    return v;
  endfunction

  // Expected read result in IDLE, given the stimulus of this edge.
  function automatic logic [DW-1:0] model_rd(input vec_t v, input logic [AW-1:0] a);
    if (ZHW && a == '0) return '0;
    if (v.we && v.wa == a) return v.wd;
    return model_mem[a];
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v, input string nm, input int idx);
    vec_t e;
    wr_en     = v.we;
    wr_addr   = v.wa;
    wr_data   = v.wd;
    rd_addr_a = v.ra;
    rd_addr_b = v.rb;
    clr_req   = v.clr;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (busy === 1'b1) busy_hi++;
    if (e.ca) check({nm, "_rd_a"}, idx, rd_data_a, e.ea);
    if (e.cb) check({nm, "_rd_b"}, idx, rd_data_b, e.eb);
    check({nm, "_busy"}, idx, {7'b0, busy}, {7'b0, e.ebusy});
  endtask

  task automatic fill(input logic [DW-1:0] base, input logic use_pattern);
    vec_t v;
    for (int i = 0; i < DEPTH; i++) begin
      v = mk(1'b1, AW'(i), use_pattern ? (base ^ DW'(i * 17)) : base, AW'(i), AW'(i), 1'b0,
             1'b0, '0, 1'b0, '0, 1'b0);
      model_mem[i] = (ZHW && i == 0) ? '0 : v.wd;
      apply(v, "fill", i);
    end
  endtask

  task automatic read_all_zero(input string nm);
    for (int i = 0; i < DEPTH; i++) begin
      apply(mk(1'b0, '0, '0, AW'(i), AW'(DEPTH - 1 - i), 1'b0, 1'b1, '0, 1'b1, '0, 1'b0), nm, i);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [DW-1:0] e0;

    e0 = ZHW ? 8'h00 : 8'h99;
    tbl[0] = mk(1'b0, 4'd0, 8'h00, 4'd3,  4'd15, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0);
    tbl[1] = mk(1'b1, 4'd5, 8'hA5, 4'd3,  4'd15, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0);
    tbl[2] = mk(1'b1, 4'd9, 8'h3C, 4'd5,  4'd5,  1'b0, 1'b1, 8'hA5, 1'b1, 8'hA5, 1'b0);
    tbl[3] = mk(1'b0, 4'd0, 8'h00, 4'd5,  4'd9,  1'b0, 1'b1, 8'hA5, 1'b1, 8'h3C, 1'b0);
    tbl[4] = mk(1'b1, 4'd7, 8'h11, 4'd9,  4'd7,  1'b0, 1'b1, 8'h3C, 1'b1, 8'h11, 1'b0);
    tbl[5] = mk(1'b1, 4'd7, 8'h22, 4'd7,  4'd5,  1'b0, 1'b1, 8'h22, 1'b1, 8'hA5, 1'b0);
    tbl[6] = mk(1'b0, 4'd0, 8'h00, 4'd7,  4'd7,  1'b0, 1'b1, 8'h22, 1'b1, 8'h22, 1'b0);
    tbl[7] = mk(1'b1, 4'd0, 8'h99, 4'd0,  4'd7,  1'b0, 1'b1, e0,    1'b1, 8'h22, 1'b0);
    tbl[8] = mk(1'b0, 4'd0, 8'h00, 4'd0,  4'd0,  1'b0, 1'b1, e0,    1'b1, e0,    1'b0);

    // Reset state, observed while reset is held.
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = 4'd3; rd_addr_b = 4'd15; clr_req = 1'b0;
    #2;
    check("reset_busy", 0, {7'b0, busy}, 8'h00);
    check("reset_rd_a", 0, rd_data_a, 8'h00);
    check("reset_rd_b", 0, rd_data_b, 8'h00);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors: reset read, dual read, same address, bypass, entry 0.
    for (int i = 0; i < 9; i++) apply(tbl[i], "vec", i);

    // Randomised idle traffic against a small array model.
    fill(8'h5A, 1'b1);
    for (int i = 0; i < 48; i++) begin
      v.we = 1'($urandom_range(0, 1));
      v.wa = AW'($urandom_range(0, DEPTH - 1));
      v.wd = DW'($urandom_range(0, 255));
      v.ra = (i % 3 == 0) ? v.wa : AW'($urandom_range(0, DEPTH - 1));
      v.rb = (i % 4 == 1) ? v.wa : AW'($urandom_range(0, DEPTH - 1));
      v.clr = 1'b0; v.ca = 1'b1; v.cb = 1'b1; v.ebusy = 1'b0;
      v.ea = model_rd(v, v.ra);
      v.eb = model_rd(v, v.rb);
      if (v.we && !(ZHW && v.wa == '0)) model_mem[v.wa] = v.wd;
      apply(v, "rand", i);
    end

    // Bulk clear: write on the start edge, dropped write and ignored clr_req while busy.
    fill(8'hFF, 1'b0);
    busy_hi = 0;
    apply(mk(1'b1, 4'd3, 8'h77, 4'd3, 4'd15, 1'b1, 1'b1, 8'h77, 1'b1, 8'hFF, 1'b1), "clr", 0);
    for (int k = 1; k <= DEPTH; k++) begin
      v = mk(k == 6, 4'd2, 8'h55, AW'(k - 1), (k == 6) ? 4'd2 : 4'd15, k == 8,
             1'b1, 8'h00, 1'b1, (k == 6 || k == DEPTH) ? 8'h00 : 8'hFF, k < DEPTH);
      apply(v, "clr", k);
    end
    apply(mk(1'b0, '0, '0, 4'd2, 4'd3, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0), "clr_after", 0);
    check("clr_busy_cycles", 0, DW'(busy_hi), DW'(DEPTH));
    read_all_zero("clr_read");

    // clr_req held high: one idle edge between back-to-back clears.
    for (int k = 0; k <= 33; k++) begin
      v = mk(1'b0, '0, '0, '0, '0, k <= 17, 1'b0, '0, 1'b0, '0,
             (k <= 15) || (k >= 17 && k <= 32));
      apply(v, "clr_hold", k);
    end

    // Reset in the sixth busy cycle aborts the clear at once.
    fill(8'hFF, 1'b0);
    apply(mk(1'b0, '0, '0, 4'd15, 4'd15, 1'b1, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1), "mid", 0);
    for (int k = 1; k <= 5; k++) begin
      apply(mk(1'b0, '0, '0, AW'(k - 1), 4'd15, 1'b0, 1'b1, 8'h00, 1'b1, 8'hFF, 1'b1), "mid", k);
    end
    #1 rst = 1'b1;
    #1;
    check("mid_rst_busy", 0, {7'b0, busy}, 8'h00);
    check("mid_rst_rd_a", 0, rd_data_a, 8'h00);
    check("mid_rst_rd_b", 0, rd_data_b, 8'h00);
    #1 rst = 1'b0;
    read_all_zero("mid_read");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
